counter8b_sweep_ctrl: RTL and testbench

Sequencer for the 8-bit up/down counter datapath. On a start request it drives a count register and its direction through a programmable number of triangular sweeps, lo→hi→lo, dwelling at each limit for a programmable hold time. It reports busy, done and err status to a host controller or test sequencer.

---
 rtl/counter8b_sweep_ctrl.sv | 147 ++++++++++++++
 tb/tb_counter8b_sweep_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/counter8b_sweep_ctrl.sv
// Triangular sweep sequencer: drives count lo->hi->lo for a programmed number
// of sweeps, dwelling hold+1 cycles at each limit, with busy/done/err status.
module counter8b_sweep_ctrl #(
  parameter int WIDTH  = 8,
  parameter int CYC_W  = 4,
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WIDTH-1:0]  lo,
  input  logic [WIDTH-1:0]  hi,
  input  logic [CYC_W-1:0]  cycles,
  input  logic [HOLD_W-1:0] hold,
  output logic [WIDTH-1:0]  count,
  output logic              dir,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    UP      = 3'd1,
    HOLD_HI = 3'd2,
    DOWN    = 3'd3,
    HOLD_LO = 3'd4
  } state_t;

  state_t              state_q;
  logic [WIDTH-1:0]    count_q;
  logic                dir_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;
  logic [WIDTH-1:0]    lo_q;
  logic [WIDTH-1:0]    hi_q;
  logic [HOLD_W-1:0]   hold_q;
  logic [CYC_W-1:0]    sweeps_left_q;
  logic [HOLD_W-1:0]   hold_cnt_q;

  // Next count values in both directions; lo<hi is enforced so neither wraps.
  logic [WIDTH-1:0]    count_inc_d;
  logic [WIDTH-1:0]    count_dec_d;
  logic                last_sweep_d;

  assign count_inc_d  = count_q + WIDTH'(1);
  assign count_dec_d  = count_q - WIDTH'(1);
  assign last_sweep_d = (sweeps_left_q == CYC_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      count_q       <= '0;
      dir_q         <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      lo_q          <= '0;
      hi_q          <= '0;
      hold_q        <= '0;
      sweeps_left_q <= '0;
      hold_cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (state_q == IDLE) begin
        if (!abort && start) begin
          if ((lo < hi) && (cycles != '0)) begin
            lo_q          <= lo;
            hi_q          <= hi;
            hold_q        <= hold;
            sweeps_left_q <= cycles;
            count_q       <= lo;
            dir_q         <= 1'b1;
            busy_q        <= 1'b1;
            state_q       <= UP;
          end else begin
            err_q <= 1'b1;
          end
        end
      end else if (abort) begin
        // Abort freezes count and dir where they are.
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          UP: begin
            count_q <= count_inc_d;
            if (count_inc_d == hi_q) begin
              state_q    <= HOLD_HI;
              hold_cnt_q <= hold_q;
            end
          end
          HOLD_HI, DOWN: begin
            if (state_q == HOLD_HI && hold_cnt_q != '0) begin
              hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
            end else begin
              count_q <= count_dec_d;
              dir_q   <= 1'b0;
              if (count_dec_d == lo_q) begin
                // Bottom of a sweep: finish the run or dwell at lo.
                sweeps_left_q <= sweeps_left_q - CYC_W'(1);
                if (last_sweep_d) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                end else begin
                  state_q    <= HOLD_LO;
                  hold_cnt_q <= hold_q;
                end
              end else begin
                state_q <= DOWN;
              end
            end
          end
          HOLD_LO: begin
            if (hold_cnt_q != '0) begin
              hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
            end else begin
              count_q <= count_inc_d;
              dir_q   <= 1'b1;
              if (count_inc_d == hi_q) begin
                state_q    <= HOLD_HI;
                hold_cnt_q <= hold_q;
              end else begin
                state_q <= UP;
              end
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign count = count_q;
  assign dir   = dir_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_counter8b_sweep_ctrl.sv
// Directed bench for counter8b_sweep_ctrl: expected per-cycle outputs are queued
// as stimulus is applied and checked one per clock after each rising edge.
module tb_counter8b_sweep_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] lo;
  logic [7:0] hi;
  logic [3:0] cycles;
  logic [3:0] hold;
  logic [7:0] count;
  logic       dir;
  logic       busy;
  logic       done;
  logic       err;

  counter8b_sweep_ctrl #(.WIDTH(8), .CYC_W(4), .HOLD_W(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .abort  (abort),
    .lo     (lo),
    .hi     (hi),
    .cycles (cycles),
    .hold   (hold),
    .count  (count),
    .dir    (dir),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] v;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  task automatic push(input int c, input logic d, input logic b, input logic dn,
                      input logic er, input string tag);
    exp_t e;
    e.v   = {c[7:0], d, b, dn, er};
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Expected trajectory of a legal run, built from the sweep shape itself.
  task automatic push_sweep(input int l, input int h, input int hd, input int cyc,
                            input string tag);
    for (int s = 0; s < cyc; s++) begin
      if (s == 0) push(l, 1'b1, 1'b1, 1'b0, 1'b0, tag);
      for (int v = l + 1; v < h; v++) push(v, 1'b1, 1'b1, 1'b0, 1'b0, tag);
      for (int k = 0; k <= hd; k++) push(h, 1'b1, 1'b1, 1'b0, 1'b0, tag);
      for (int v = h - 1; v > l; v--) push(v, 1'b0, 1'b1, 1'b0, 1'b0, tag);
      if (s == cyc - 1) push(l, 1'b0, 1'b0, 1'b1, 1'b0, tag);
      else for (int k = 0; k <= hd; k++) push(l, 1'b0, 1'b1, 1'b0, 1'b0, tag);
    end
  endtask

  // Consume the queue one clock per entry; start drops after start_edges edges.
  task automatic run(input int start_edges, input bit scramble, input string name);
    int          n;
    exp_t        e;
    logic [11:0] obs;
    n = 0;
    while (exp_q.size() != 0) begin
      @(posedge clk);
      #1;
      n++;
      if (n >= start_edges) start = 1'b0;
      if (scramble && n == 1) begin
        lo = 8'd9; hi = 8'd3; cycles = 4'd0; hold = 4'd15;
      end
      obs = {count, dir, busy, done, err};
      e = exp_q.pop_front();
      vectors++;
      assert (obs === e.v) else begin
        miscompares++;
        $error("FAIL %s cycle %0d: observed count=%0d dir=%b busy=%b done=%b err=%b, expected count=%0d dir=%b busy=%b done=%b err=%b",
               e.tag, n, obs[11:4], obs[3], obs[2], obs[1], obs[0],
               e.v[11:4], e.v[3], e.v[2], e.v[1], e.v[0]);
      end
    end
    $display("run %s: %0d cycles checked", name, n);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    lo = 8'd0; hi = 8'd0; cycles = 4'd0; hold = 4'd0;

    for (int i = 0; i < 2; i++) push(0, 1'b1, 1'b0, 1'b0, 1'b0, "reset");
    run(0, 1'b0, "reset");
    reset = 1'b0;
    for (int i = 0; i < 10; i++) push(0, 1'b1, 1'b0, 1'b0, 1'b0, "idle");
    run(0, 1'b0, "idle");

    lo = 8'd2; hi = 8'd5; hold = 4'd0; cycles = 4'd1; start = 1'b1;
    push_sweep(2, 5, 0, 1, "basic");
    push(2, 1'b0, 1'b0, 1'b0, 1'b0, "basic_after");
    run(1, 1'b0, "basic");

    // Start held while busy and inputs changed mid-run must not disturb the run.
    lo = 8'd2; hi = 8'd5; hold = 4'd2; cycles = 4'd2; start = 1'b1;
    push_sweep(2, 5, 2, 2, "dwell2");
    push(2, 1'b0, 1'b0, 1'b0, 1'b0, "dwell2_after");
    run(3, 1'b1, "dwell2");

    lo = 8'd7; hi = 8'd8; hold = 4'd0; cycles = 4'd3; start = 1'b1;
    push_sweep(7, 8, 0, 3, "adjacent");
    push(7, 1'b0, 1'b0, 1'b0, 1'b0, "adjacent_after");
    run(1, 1'b0, "adjacent");

    lo = 8'd9; hi = 8'd9; cycles = 4'd1; start = 1'b1;
    push(7, 1'b0, 1'b0, 1'b0, 1'b1, "illegal_eq");
    push(7, 1'b0, 1'b0, 1'b0, 1'b0, "illegal_eq_after");
    run(1, 1'b0, "illegal_eq");

    lo = 8'd1; hi = 8'd4; cycles = 4'd0; start = 1'b1;
    push(7, 1'b0, 1'b0, 1'b0, 1'b1, "illegal_cyc0");
    push(7, 1'b0, 1'b0, 1'b0, 1'b0, "illegal_cyc0_after");
    run(1, 1'b0, "illegal_cyc0");

    lo = 8'd0; hi = 8'd255; hold = 4'd0; cycles = 4'd1; start = 1'b1;
    for (int v = 0; v <= 100; v++) push(v, 1'b1, 1'b1, 1'b0, 1'b0, "full_ramp");
    run(1, 1'b0, "full_ramp");
    abort = 1'b1;
    push(100, 1'b1, 1'b0, 1'b0, 1'b0, "abort");
    run(1, 1'b0, "abort");
    abort = 1'b0;
    push(100, 1'b1, 1'b0, 1'b0, 1'b0, "abort_after");
    run(1, 1'b0, "abort_after");

    start = 1'b1;
    for (int v = 0; v <= 50; v++) push(v, 1'b1, 1'b1, 1'b0, 1'b0, "restart");
    run(1, 1'b0, "restart");
    reset = 1'b1;
    push(0, 1'b1, 1'b0, 1'b0, 1'b0, "midrun_reset");
    run(1, 1'b0, "midrun_reset");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) push(0, 1'b1, 1'b0, 1'b0, 1'b0, "post_reset");
    run(1, 1'b0, "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
